// File: rtl/control_sequencer_pkg.sv
// +--------------------------------------------------------------------------+
// | control_sequencer_pkg                                                     |
// | Opcodes, state/class encodings and bundled-port bit indices shared by     |
// | the control sequencer and its opcode class decoder.                       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package control_sequencer_pkg;

    localparam int OP_LD   = 0;
    localparam int OP_LDI  = 1;
    localparam int OP_ST   = 2;
    localparam int OP_ADD  = 3;
    localparam int OP_SHL  = 11;
    localparam int OP_ADDI = 12;
    localparam int OP_ORI  = 14;
    localparam int OP_BRZR = 19;
    localparam int OP_JR   = 20;
    localparam int OP_NOP  = 26;
    localparam int OP_HALT = 27;

    // gr_sel {Gra,Grb,Grc}
    localparam int GR_A = 2;
    localparam int GR_B = 1;
    localparam int GR_C = 0;
    // reg_ctl {Rin,Rout,BAout,Cout}
    localparam int RC_RIN   = 3;
    localparam int RC_ROUT  = 2;
    localparam int RC_BAOUT = 1;
    localparam int RC_COUT  = 0;
    // drv_sel {PCout,MDRout,Zlowout}
    localparam int DRV_PC  = 2;
    localparam int DRV_MDR = 1;
    localparam int DRV_ZLO = 0;
    // ld_en {PCin,IncPC,MARin,MDRin,IRin,Yin,Zin,CONin}
    localparam int LD_PC   = 7;
    localparam int LD_INC  = 6;
    localparam int LD_MAR  = 5;
    localparam int LD_MDR  = 4;
    localparam int LD_IR   = 3;
    localparam int LD_Y    = 2;
    localparam int LD_Z    = 1;
    localparam int LD_CON  = 0;
    // mem_ctl {Read,Write}
    localparam int MEM_RD = 1;
    localparam int MEM_WR = 0;

    typedef enum logic [3:0] {
        ST_RST   = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_T7    = 4'd8,
        ST_HALT  = 4'd9,
        ST_ERR   = 4'd10,
        ST_PAUSE = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE = 4'd0,
        CL_IMM   = 4'd1,
        CL_LDI   = 4'd2,
        CL_LD    = 4'd3,
        CL_ST    = 4'd4,
        CL_BR    = 4'd5,
        CL_JR    = 4'd6,
        CL_NOP   = 4'd7,
        CL_HALT  = 4'd8
    } iclass_t;

endpackage

`default_nettype wire

// File: rtl/control_sequencer_decode.sv
// +--------------------------------------------------------------------------+
// | control_sequencer_decode                                                  |
// | Opcode class decoder: opcode -> instruction class (unsupported -> NOP).   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module control_sequencer_decode
    import control_sequencer_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode_i,
    output iclass_t        class_o
);

    always_comb begin
        class_o = CL_NOP;
        if (opcode_i >= OPW'(OP_ADD) && opcode_i <= OPW'(OP_SHL)) begin
            class_o = CL_RTYPE;
        end else if (opcode_i >= OPW'(OP_ADDI) && opcode_i <= OPW'(OP_ORI)) begin
            class_o = CL_IMM;
        end else begin
            case (opcode_i)
                OPW'(OP_LD):   class_o = CL_LD;
                OPW'(OP_LDI):  class_o = CL_LDI;
                OPW'(OP_ST):   class_o = CL_ST;
                OPW'(OP_BRZR): class_o = CL_BR;
                OPW'(OP_JR):   class_o = CL_JR;
                OPW'(OP_HALT): class_o = CL_HALT;
                default:       class_o = CL_NOP;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// +--------------------------------------------------------------------------+
// | control_sequencer                                                         |
// | Mini SRC control unit: steps T0..T7 per instruction class and drives the  |
// | register-select, bus-driver, load-enable, ALU and memory controls.        |
// | Optional: SINGLE_STEP_EN adds step_i and a PAUSE between instructions.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int OPW         = 5
) (
    input  logic           clk,
    input  logic           clear,
`ifdef SINGLE_STEP_EN
    input  logic           step_i,
`endif
    input  logic [31:0]    ir_i,
    input  logic           mem_rdy_i,
    input  logic           con_ff_i,
    output logic [2:0]     gr_sel_o,
    output logic [3:0]     reg_ctl_o,
    output logic [2:0]     drv_sel_o,
    output logic [7:0]     ld_en_o,
    output logic [1:0]     mem_ctl_o,
    output logic [OPW-1:0] alu_op_o,
    output logic           run_o,
    output logic           err_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [OPW-1:0]   op_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OPW-1:0]   dec_op;
    iclass_t          cls;
    state_t           end_st;
    logic             mem_wait;
    logic             timeout;
    logic             unused_ir_bits;

    assign unused_ir_bits = ^ir_i[31-OPW:0];

    // In T2 the IR is still being loaded, so decode straight from ir_i there.
    assign dec_op = (state_q == ST_T2) ? ir_i[31 -: OPW] : op_q;

    control_sequencer_decode #(.OPW(OPW)) u_decode (
        .opcode_i (dec_op),
        .class_o  (cls)
    );

`ifdef SINGLE_STEP_EN
    assign end_st = ST_PAUSE;
`else
    assign end_st = ST_T0;
`endif

    assign mem_wait = (state_q == ST_T1)
                   || (state_q == ST_T6 && cls == CL_LD)
                   || (state_q == ST_T7 && cls == CL_ST);
    assign timeout  = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= ST_RST;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_T2) begin
                op_q <= ir_i[31 -: OPW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1: begin
                if (mem_rdy_i)    state_d = ST_T2;
                else if (timeout) state_d = ST_ERR;
            end
            ST_T2: begin
                if (cls == CL_HALT)     state_d = ST_HALT;
                else if (cls == CL_NOP) state_d = end_st;
                else                    state_d = ST_T3;
            end
            ST_T3: state_d = (cls == CL_JR) ? end_st : ST_T4;
            ST_T4: state_d = ST_T5;
            ST_T5: begin
                if (cls == CL_LD || cls == CL_ST || cls == CL_BR) state_d = ST_T6;
                else                                              state_d = end_st;
            end
            ST_T6: begin
                if (cls == CL_BR)     state_d = end_st;
                else if (cls == CL_ST) state_d = ST_T7;
                else if (mem_rdy_i)    state_d = ST_T7;
                else if (timeout)      state_d = ST_ERR;
            end
            ST_T7: begin
                if (cls != CL_ST || mem_rdy_i) state_d = end_st;
                else if (timeout)              state_d = ST_ERR;
            end
`ifdef SINGLE_STEP_EN
            ST_PAUSE: if (step_i) state_d = ST_T0;
`else
            ST_PAUSE: state_d = ST_T0;
`endif
            default: state_d = state_q;
        endcase
    end

    // The wait counter restarts from zero whenever a wait state is (re)entered.
    always_comb begin
        cnt_d = '0;
        if (mem_wait && state_d == state_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        gr_sel_o  = '0;
        reg_ctl_o = '0;
        drv_sel_o = '0;
        ld_en_o   = '0;
        mem_ctl_o = '0;
        alu_op_o  = '0;
        run_o     = 1'b0;
        err_o     = (state_q == ST_ERR);
        case (state_q)
            ST_T0: begin
                run_o             = 1'b1;
                drv_sel_o[DRV_PC] = 1'b1;
                ld_en_o[LD_MAR]   = 1'b1;
                ld_en_o[LD_INC]   = 1'b1;
                ld_en_o[LD_Z]     = 1'b1;
            end
            ST_T1: begin
                run_o              = 1'b1;
                drv_sel_o[DRV_ZLO] = 1'b1;
                ld_en_o[LD_PC]     = 1'b1;
                mem_ctl_o[MEM_RD]  = 1'b1;
                ld_en_o[LD_MDR]    = mem_rdy_i;
            end
            ST_T2: begin
                run_o              = 1'b1;
                drv_sel_o[DRV_MDR] = 1'b1;
                ld_en_o[LD_IR]     = 1'b1;
            end
            ST_T3: begin
                run_o = 1'b1;
                case (cls)
                    CL_RTYPE, CL_IMM: begin
                        gr_sel_o[GR_B]     = 1'b1;
                        reg_ctl_o[RC_ROUT] = 1'b1;
                        ld_en_o[LD_Y]      = 1'b1;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        gr_sel_o[GR_B]      = 1'b1;
                        reg_ctl_o[RC_BAOUT] = 1'b1;
                        ld_en_o[LD_Y]       = 1'b1;
                    end
                    CL_BR: begin
                        gr_sel_o[GR_A]     = 1'b1;
                        reg_ctl_o[RC_ROUT] = 1'b1;
                        ld_en_o[LD_CON]    = 1'b1;
                    end
                    CL_JR: begin
                        gr_sel_o[GR_A]     = 1'b1;
                        reg_ctl_o[RC_ROUT] = 1'b1;
                        ld_en_o[LD_PC]     = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                run_o = 1'b1;
                case (cls)
                    CL_RTYPE: begin
                        gr_sel_o[GR_C]     = 1'b1;
                        reg_ctl_o[RC_ROUT] = 1'b1;
                        ld_en_o[LD_Z]      = 1'b1;
                        alu_op_o           = op_q;
                    end
                    CL_IMM: begin
                        reg_ctl_o[RC_COUT] = 1'b1;
                        ld_en_o[LD_Z]      = 1'b1;
                        alu_op_o           = op_q;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        reg_ctl_o[RC_COUT] = 1'b1;
                        ld_en_o[LD_Z]      = 1'b1;
                        alu_op_o           = OPW'(OP_ADD);
                    end
                    CL_BR: begin
                        drv_sel_o[DRV_PC] = 1'b1;
                        ld_en_o[LD_Y]     = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                run_o = 1'b1;
                case (cls)
                    CL_RTYPE, CL_IMM, CL_LDI: begin
                        drv_sel_o[DRV_ZLO] = 1'b1;
                        gr_sel_o[GR_A]     = 1'b1;
                        reg_ctl_o[RC_RIN]  = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        drv_sel_o[DRV_ZLO] = 1'b1;
                        ld_en_o[LD_MAR]    = 1'b1;
                    end
                    CL_BR: begin
                        reg_ctl_o[RC_COUT] = 1'b1;
                        ld_en_o[LD_Z]      = 1'b1;
                        alu_op_o           = OPW'(OP_ADD);
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                run_o = 1'b1;
                case (cls)
                    CL_LD: begin
                        mem_ctl_o[MEM_RD] = 1'b1;
                        ld_en_o[LD_MDR]   = mem_rdy_i;
                    end
                    CL_ST: begin
                        gr_sel_o[GR_A]     = 1'b1;
                        reg_ctl_o[RC_ROUT] = 1'b1;
                        ld_en_o[LD_MDR]    = 1'b1;
                    end
                    CL_BR: begin
                        drv_sel_o[DRV_ZLO] = con_ff_i;
                        ld_en_o[LD_PC]     = con_ff_i;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                run_o = 1'b1;
                case (cls)
                    CL_LD: begin
                        drv_sel_o[DRV_MDR] = 1'b1;
                        gr_sel_o[GR_A]     = 1'b1;
                        reg_ctl_o[RC_RIN]  = 1'b1;
                    end
                    CL_ST: mem_ctl_o[MEM_WR] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
